// File: rtl/nes_pkg.sv
// nes_pkg: controller button count and bit-order constants shared by pad and reader sides
package nes_pkg;
  localparam int NUM_BUTTONS = 8;
  localparam int BTN_A       = 0;
  localparam int BTN_B       = 1;
  localparam int BTN_SELECT  = 2;
  localparam int BTN_START   = 3;
  localparam int BTN_UP      = 4;
  localparam int BTN_DOWN    = 5;
  localparam int BTN_LEFT    = 6;
  localparam int BTN_RIGHT   = 7;
endpackage

// File: rtl/nes_debounce.sv
// nes_debounce: one-button debouncer (CLOCK_50, reset, raw in, level out); level follows raw after DEBOUNCE_CYCLES consecutive differing clocks
module nes_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) cnt <= '0;
    else if (cnt == LAST) begin
      cnt   <= '0;
      level <= raw;
    end else cnt <= cnt + CW'(1);
endmodule

// File: rtl/nes_pad_responder.sv
// nes_pad_responder: NES pad emulation (CLOCK_50, reset, latch, pulse, buttons[8] in; data_out, buttons_db, poll_strobe, shift_count out)
import nes_pkg::*;
module nes_pad_responder #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   latch,
  input  logic                   pulse,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   data_out,
  output logic [NUM_BUTTONS-1:0] buttons_db,
  output logic                   poll_strobe,
  output logic [3:0]             shift_count
);
  logic l_s1, l_s2, l_d, p_s1, p_s2, p_d;
  logic [NUM_BUTTONS-1:0] sr;
  genvar i;
  generate
    for (i = 0; i < NUM_BUTTONS; i++) begin : g_db
      nes_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .raw     (buttons[i]),
        .level   (buttons_db[i])
      );
    end
  endgenerate
  assign data_out = sr[0];
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      {l_s1, l_s2, l_d, p_s1, p_s2, p_d} <= '0;
      sr          <= '1;
      shift_count <= '0;
      poll_strobe <= 1'b0;
    end else begin
      {l_s1, l_s2, l_d} <= {latch, l_s1, l_s2};
      {p_s1, p_s2, p_d} <= {pulse, p_s1, p_s2};
      poll_strobe <= l_d & ~l_s2;
      if (l_s2) begin
        sr          <= ~buttons_db;
        shift_count <= '0;
      end else if (p_s2 & ~p_d) begin
        sr          <= {1'b1, sr[NUM_BUTTONS-1:1]};
        shift_count <= (shift_count == 4'd8) ? 4'd8 : shift_count + 4'd1;
      end
    end
endmodule
